// File: rtl/frame_source.sv
// Framed 32-bit test-traffic source feeding the data_gateway write FIFO.
// Optional checksum trailer enabled by defining FRAME_SOURCE_CHECKSUM_EN.
module frame_source #(
   parameter logic [15:0] SYNC_WORD     = 16'hA55A,
   parameter int          PAYLOAD_BYTES = 1021,
   parameter int          GAP_CYCLES    = 8
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        enable_in,
   input  logic        full_in,
   output logic        wr_en_out,
   output logic [31:0] data_out,
   output logic [3:0]  be_out,
   output logic        busy_out,
   output logic        frame_done_out,
   output logic [15:0] frame_cnt_out
);

   localparam int          PAYLOAD_WORDS = (PAYLOAD_BYTES + 3) / 4;
   localparam int          LAST_LANES    = PAYLOAD_BYTES % 4;
   localparam logic [3:0]  LAST_BE       = (LAST_LANES == 0) ? 4'hF : 4'((1 << LAST_LANES) - 1);
   localparam logic [31:0] LAST_MASK     = {{8{LAST_BE[3]}}, {8{LAST_BE[2]}},
                                            {8{LAST_BE[1]}}, {8{LAST_BE[0]}}};
   localparam logic [17:0] K_LAST        = 18'(PAYLOAD_WORDS - 1);
   localparam logic [15:0] GAP_LAST      = 16'(GAP_CYCLES - 1);

`ifdef FRAME_SOURCE_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, TRAILER, GAP} state_t;
`else
   typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, GAP} state_t;
`endif

   state_t      state, state_nxt, after_frame;
   logic [17:0] k;
   logic [15:0] gap_cnt;
   logic        valid;
   logic        frame_last;
`ifdef FRAME_SOURCE_CHECKSUM_EN
   logic [31:0] csum;
`endif

   // Handshake: valid is the source's offer; full_in is the FIFO's back-pressure.
   // A word transfers only in a clock with valid=1 and full_in=0 (wr_en_out=1);
   // otherwise state, data_out and be_out hold, so nothing is dropped or repeated.
   assign wr_en_out = valid & ~full_in;
   assign busy_out  = (state != IDLE);

   always_comb begin
      state_nxt   = state;
      valid       = 1'b0;
      data_out    = '0;
      be_out      = '0;
      frame_last  = 1'b0;
      after_frame = (GAP_CYCLES == 0) ? (enable_in ? HEADER : IDLE) : GAP;
      case (state)
         IDLE: begin
            if (enable_in) state_nxt = HEADER;
         end
         HEADER: begin
            valid    = 1'b1;
            data_out = {SYNC_WORD, frame_cnt_out};
            be_out   = 4'hF;
            if (!full_in) state_nxt = PAYLOAD;
         end
         PAYLOAD: begin
            valid = 1'b1;
            if (k == K_LAST) begin
               data_out = {frame_cnt_out, k[15:0]} & LAST_MASK;
               be_out   = LAST_BE;
               if (!full_in) begin
`ifdef FRAME_SOURCE_CHECKSUM_EN
                  state_nxt = TRAILER;
`else
                  frame_last = 1'b1;
                  state_nxt  = after_frame;
`endif
               end
            end else begin
               data_out = {frame_cnt_out, k[15:0]};
               be_out   = 4'hF;
            end
         end
`ifdef FRAME_SOURCE_CHECKSUM_EN
         TRAILER: begin
            valid    = 1'b1;
            data_out = csum;
            be_out   = 4'hF;
            if (!full_in) begin
               frame_last = 1'b1;
               state_nxt  = after_frame;
            end
         end
`endif
         GAP: begin
            if (gap_cnt == GAP_LAST) state_nxt = enable_in ? HEADER : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state          <= IDLE;
         k              <= '0;
         gap_cnt        <= '0;
         frame_done_out <= 1'b0;
         frame_cnt_out  <= '0;
      end else begin
         state          <= state_nxt;
         frame_done_out <= frame_last;
         if (frame_last) frame_cnt_out <= frame_cnt_out + 16'd1;
         if (state == HEADER) k <= '0;
         else if (state == PAYLOAD && wr_en_out) k <= k + 18'd1;
         if (state != GAP) gap_cnt <= '0;
         else gap_cnt <= gap_cnt + 16'd1;
      end
   end

`ifdef FRAME_SOURCE_CHECKSUM_EN
   // Accumulates the masked words exactly as written, so the trailer matches the wire.
   always_ff @(posedge clk_in) begin
      if (rst_in) csum <= '0;
      else if (state_nxt == HEADER && state != HEADER) csum <= '0;
      else if (wr_en_out && (state == HEADER || state == PAYLOAD)) csum <= csum ^ data_out;
   end
`endif

endmodule

// File: tb/tb_frame_source.sv
// Bench for frame_source: directed phases plus randomized back-pressure,
// scored against a frame model built from byte counts and lane arithmetic.
module tb_frame_source;

   localparam int PB_A  = 10;
   localparam int GAP_A = 2;
   localparam int PB_B  = 4;
   localparam int GAP_B = 0;
`ifdef FRAME_SOURCE_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif
   localparam int L_A = 1 + (PB_A + 3) / 4 + (CSUM ? 1 : 0);
   localparam int L_B = 1 + (PB_B + 3) / 4 + (CSUM ? 1 : 0);
   localparam int P_A = L_A + GAP_A;
   localparam int K_RAND = 4;

   logic clk = 1'b0;
   logic rst, en_a, full_a, en_b, full_b;
   logic        wr_en [2];
   logic [31:0] data  [2];
   logic [3:0]  be    [2];
   logic        busy  [2];
   logic        done  [2];
   logic [15:0] cnt   [2];

   int checks = 0;
   int errors = 0;
   logic [36:0] exp_q_a [$];
   logic [36:0] exp_q_b [$];
   logic [15:0] model_cnt [2];
   logic        pending   [2];
   logic        last_wr   [2];
   logic        last_busy [2];
   logic [31:0] last_data [2];
   logic [3:0]  last_be   [2];

   always #5 clk = ~clk;

   frame_source #(.SYNC_WORD(16'hA55A), .PAYLOAD_BYTES(PB_A), .GAP_CYCLES(GAP_A)) dut_a (
      .clk_in(clk), .rst_in(rst), .enable_in(en_a), .full_in(full_a),
      .wr_en_out(wr_en[0]), .data_out(data[0]), .be_out(be[0]), .busy_out(busy[0]),
      .frame_done_out(done[0]), .frame_cnt_out(cnt[0]));

   frame_source #(.SYNC_WORD(16'hA55A), .PAYLOAD_BYTES(PB_B), .GAP_CYCLES(GAP_B)) dut_b (
      .clk_in(clk), .rst_in(rst), .enable_in(en_b), .full_in(full_b),
      .wr_en_out(wr_en[1]), .data_out(data[1]), .be_out(be[1]), .busy_out(busy[1]),
      .frame_done_out(done[1]), .frame_cnt_out(cnt[1]));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic int qsize(input int u);
      return (u == 0) ? exp_q_a.size() : exp_q_b.size();
   endfunction

   task automatic push(input int u, input logic [36:0] e);
      if (u == 0) exp_q_a.push_back(e);
      else exp_q_b.push_back(e);
   endtask

   // Frame model: {last, be, data} per word, derived from byte counts per word.
   task automatic push_frame(input int u, input logic [15:0] n);
      int pb, words, lanes;
      logic [31:0] w, cs;
      logic [3:0] b;
      pb    = (u == 0) ? PB_A : PB_B;
      words = (pb + 3) / 4;
      w     = {16'hA55A, n};
      cs    = w;
      push(u, {1'b0, 4'hF, w});
      for (int i = 0; i < words; i++) begin
         lanes = pb - 4 * i;
         if (lanes > 4) lanes = 4;
         b = 4'((1 << lanes) - 1);
         w = {n, 16'(i)};
         for (int l = lanes; l < 4; l++) w[8*l +: 8] = 8'h00;
         cs ^= w;
         push(u, {(i == words - 1) && !CSUM, b, w});
      end
      if (CSUM) push(u, {1'b1, 4'hF, cs});
   endtask

   task automatic check_writes(input int u, input logic fu);
      logic [36:0] e;
      last_wr[u]   = wr_en[u];
      last_busy[u] = busy[u];
      last_data[u] = data[u];
      last_be[u]   = be[u];
      pending[u]   = 1'b0;
      if (!rst) begin
         if (fu) chk($sformatf("u%0d_wr_en_while_full", u), 64'(wr_en[u]), 64'(0));
         if (wr_en[u]) begin
            if (qsize(u) == 0) begin
               chk($sformatf("u%0d_spurious_write", u), 64'(wr_en[u]), 64'(0));
            end else begin
               if (u == 0) e = exp_q_a.pop_front();
               else e = exp_q_b.pop_front();
               chk($sformatf("u%0d_data", u), 64'(data[u]), 64'(e[31:0]));
               chk($sformatf("u%0d_be", u), 64'(be[u]), 64'(e[35:32]));
               pending[u] = e[36];
            end
         end
      end
   endtask

   task automatic check_regs(input int u);
      if (rst) begin
         chk($sformatf("u%0d_rst_wr_en", u), 64'(wr_en[u]), 64'(0));
         chk($sformatf("u%0d_rst_data", u), 64'(data[u]), 64'(0));
         chk($sformatf("u%0d_rst_be", u), 64'(be[u]), 64'(0));
         chk($sformatf("u%0d_rst_busy", u), 64'(busy[u]), 64'(0));
         chk($sformatf("u%0d_rst_done", u), 64'(done[u]), 64'(0));
         chk($sformatf("u%0d_rst_cnt", u), 64'(cnt[u]), 64'(0));
         if (u == 0) exp_q_a.delete();
         else exp_q_b.delete();
         model_cnt[u] = 16'h0000;
         pending[u]   = 1'b0;
      end else begin
         if (pending[u]) model_cnt[u] = model_cnt[u] + 16'd1;
         chk($sformatf("u%0d_frame_done", u), 64'(done[u]), 64'(pending[u]));
         chk($sformatf("u%0d_frame_cnt", u), 64'(cnt[u]), 64'(model_cnt[u]));
      end
   endtask

   task automatic tick(input logic r, input logic ea, input logic fa, input logic eb);
      rst = r; en_a = ea; full_a = fa; en_b = eb; full_b = 1'b0;
      #1;
      check_writes(0, fa);
      check_writes(1, 1'b0);
      @(posedge clk);
      #1;
      check_regs(0);
      check_regs(1);
   endtask

   initial begin
      logic [15:0] start, diff;
      rst = 1'b1; en_a = 1'b0; full_a = 1'b0; en_b = 1'b0; full_b = 1'b0;
      model_cnt[0] = '0; model_cnt[1] = '0;
      pending[0] = 1'b0; pending[1] = 1'b0;

      // Reset, then two frames; enable dropped during frame 1 payload.
      tick(1, 0, 0, 0);
      tick(1, 0, 0, 0);
      push_frame(0, 16'h0000);
      push_frame(0, 16'h0001);
      for (int j = 0; j <= 2 * P_A + 3; j++) begin
         tick(0, (j <= P_A + 2), 0, 0);
         chk($sformatf("p1_wr_en_%0d", j), 64'(last_wr[0]),
             64'((j >= 1) && (j <= 2 * P_A) && (((j - 1) % P_A) < L_A)));
         chk($sformatf("p1_busy_%0d", j), 64'(last_busy[0]), 64'((j >= 1) && (j <= 2 * P_A)));
      end
      chk("p1_queue_drained", 64'(qsize(0)), 64'(0));

      // Reset mid-payload abandons the frame.
      push_frame(0, model_cnt[0]);
      tick(0, 1, 0, 0);
      tick(0, 1, 0, 0);
      tick(0, 1, 0, 0);
      tick(1, 1, 0, 0);

      // Restart, then hold the second payload word under back-pressure.
      push_frame(0, 16'h0000);
      tick(0, 1, 0, 0);
      chk("p3_idle_after_reset_wr_en", 64'(last_wr[0]), 64'(0));
      tick(0, 1, 0, 0);
      tick(0, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         tick(0, 0, 1, 0);
         chk($sformatf("p3_hold_data_%0d", i), 64'(last_data[0]), 64'(32'h0000_0001));
         chk($sformatf("p3_hold_be_%0d", i), 64'(last_be[0]), 64'(4'hF));
      end
      for (int i = 0; i < 30 && (qsize(0) != 0 || last_busy[0]); i++) tick(0, 0, 0, 0);
      chk("p3_queue_drained", 64'(qsize(0)), 64'(0));
      chk("p3_idle", 64'(busy[0]), 64'(0));

      // Random back-pressure across several frames.
      start = model_cnt[0];
      for (int f = 0; f < K_RAND; f++) push_frame(0, start + 16'(f));
      for (int i = 0; i < 600 && (qsize(0) != 0 || last_busy[0]); i++) begin
         diff = model_cnt[0] - start;
         tick(0, (diff < 16'(K_RAND)), ($urandom_range(0, 3) == 0), 0);
      end
      chk("p4_queue_drained", 64'(qsize(0)), 64'(0));
      chk("p4_idle", 64'(busy[0]), 64'(0));
      chk("p4_frame_cnt", 64'(cnt[0]), 64'(start + 16'(K_RAND)));

      // Counter wrap on the single-word, zero-gap instance.
      force dut_b.frame_cnt_out = 16'hFFFF;
      model_cnt[1] = 16'hFFFF;
      tick(0, 0, 0, 0);
      release dut_b.frame_cnt_out;
      push_frame(1, 16'hFFFF);
      push_frame(1, 16'h0000);
      for (int j = 0; j <= 2 * L_B + 1; j++) begin
         tick(0, 0, 0, (j <= L_B + 1));
         chk($sformatf("p5_wr_en_%0d", j), 64'(last_wr[1]), 64'((j >= 1) && (j <= 2 * L_B)));
         chk($sformatf("p5_busy_%0d", j), 64'(last_busy[1]), 64'((j >= 1) && (j <= 2 * L_B)));
      end
      chk("p5_queue_drained", 64'(qsize(1)), 64'(0));
      chk("p5_frame_cnt", 64'(cnt[1]), 64'(16'h0001));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
